// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD widths, add-3 threshold and digit types
package bcd_pkg;
  localparam int BCD_NIBBLE_W = 4;
  localparam logic [3:0] ADD3_THRESHOLD = 4'd5;
  typedef logic [BCD_NIBBLE_W-1:0] bcd_digit_t;
  typedef logic [3*BCD_NIBBLE_W-1:0] bcd3_t;
endpackage

// File: rtl/bcd_add3.sv
// bcd_add3: one double-dabble digit correction, adds 3 when the digit is 5 or more
module bcd_add3
  import bcd_pkg::*;
(
  input  bcd_digit_t din,
  output bcd_digit_t dout
);
  assign dout = (din >= ADD3_THRESHOLD) ? din + 4'd3 : din;
endmodule

// File: rtl/bcd_encoder.sv
// bcd_encoder: binary to packed BCD via combinational double-dabble, registered output
module bcd_encoder
  import bcd_pkg::*;
#(
  parameter int BIN_W      = 8,
  parameter int BCD_DIGITS = 3
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [BIN_W-1:0]                   BinaryIn,
  output logic [BCD_DIGITS*BCD_NIBBLE_W-1:0] BCDOut
);
  localparam int W = BCD_DIGITS * BCD_NIBBLE_W;
  logic [BIN_W:0][W-1:0]   st;
  logic [BIN_W-1:0][W-1:0] adj;
  logic [BIN_W-1:0]        unused_msb;
  assign st[0] = '0;
  for (genvar s = 0; s < BIN_W; s++) begin : g_stage
    for (genvar d = 0; d < BCD_DIGITS; d++) begin : g_digit
      bcd_add3 u_add3 (
        .din (st[s][d*BCD_NIBBLE_W +: BCD_NIBBLE_W]),
        .dout(adj[s][d*BCD_NIBBLE_W +: BCD_NIBBLE_W])
      );
    end
    // the top digit's MSB shifts out and is provably zero for in-range inputs
    assign st[s+1]       = {adj[s][W-2:0], BinaryIn[BIN_W-1-s]};
    assign unused_msb[s] = adj[s][W-1];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) BCDOut <= '0;
    else        BCDOut <= st[BIN_W];
endmodule

// File: tb/tb_bcd_encoder.sv
// tb_bcd_encoder: directed checks of conversion, latency, reset and invariants
module tb_bcd_encoder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  BinaryIn;
  logic [11:0] BCDOut;
  int passed = 0;
  int total  = 0;

  bcd_encoder dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .BinaryIn(BinaryIn),
    .BCDOut  (BCDOut)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] bcd_ref(input int v);
    logic [3:0] h, t, u;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    u = 4'(v % 10);
    return {h, t, u};
  endfunction

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    logic ok;
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    ok = (obs[3:0] <= 4'd9) && (obs[7:4] <= 4'd9) && (obs[11:8] <= 4'd9) && (obs[11:10] == 2'b00);
    total = total + 1;
    assert (ok === 1'b1) passed = passed + 1;
    else $error("FAIL %s_invariant observed=%h expected=nibbles<=9,[11:10]=0", tag, obs);
  endtask

  task automatic step(input logic [7:0] v);
    BinaryIn = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] bnd [7];
    bnd = '{8'd9, 8'd10, 8'd99, 8'd100, 8'd199, 8'd200, 8'd255};
    rst_n    = 1'b1;
    BinaryIn = 8'd0;
    #2 rst_n = 1'b0;
    #1 chk("reset_async", BCDOut, 12'h000);
    @(posedge clk); #1;
    chk("reset_hold", BCDOut, 12'h000);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 256; i++) begin
      step(8'(i));
      chk($sformatf("sweep_%0d", i), BCDOut, bcd_ref(i));
    end
    for (int i = 0; i < 7; i++) begin
      step(bnd[i]);
      chk($sformatf("boundary_%0d", bnd[i]), BCDOut, bcd_ref(int'(bnd[i])));
    end
    step(8'd37);
    chk("latency_37", BCDOut, 12'h037);
    BinaryIn = 8'd142;
    #2 chk("latency_lag", BCDOut, 12'h037);
    @(posedge clk); #1;
    chk("latency_142", BCDOut, 12'h142);
    BinaryIn = 8'd5;
    #2 chk("midcycle_5", BCDOut, 12'h142);
    BinaryIn = 8'd6;
    #2 chk("midcycle_6", BCDOut, 12'h142);
    BinaryIn = 8'd7;
    @(posedge clk); #1;
    chk("midcycle_edge", BCDOut, 12'h007);
    BinaryIn = 8'd200;
    #2 rst_n = 1'b0;
    #1 chk("reset_mid", BCDOut, 12'h000);
    @(posedge clk); #1;
    chk("reset_mid_hold", BCDOut, 12'h000);
    @(negedge clk) rst_n = 1'b1;
    #2 chk("reset_release_noedge", BCDOut, 12'h000);
    @(posedge clk); #1;
    chk("reset_release_200", BCDOut, 12'h200);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
